// File: rtl/nios_cpu_pio_pkg.sv
// Shared constants for the Nios II input PIO: register map, edge and irq source encodings.
package nios_cpu_pio_pkg;

  localparam int unsigned REG_W  = 32;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned ARM_W  = 2;

  typedef logic [ADDR_W-1:0] avs_addr_t;

  localparam avs_addr_t ADDR_DATA = ADDR_W'(0);
  localparam avs_addr_t ADDR_DIR  = ADDR_W'(1);
  localparam avs_addr_t ADDR_MASK = ADDR_W'(2);
  localparam avs_addr_t ADDR_EDGE = ADDR_W'(3);

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  localparam int unsigned IRQ_NONE  = 0;
  localparam int unsigned IRQ_LEVEL = 1;
  localparam int unsigned IRQ_EDGE  = 2;

  // Arming counter value at which edge detection is enabled.
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(3);

endpackage

// File: rtl/nios_cpu_pio_in_if.sv
// Avalon-MM slave bus plus interrupt line of the input PIO.
interface nios_cpu_pio_in_if;
  import nios_cpu_pio_pkg::*;

  avs_addr_t         address;
  logic              chipselect;
  logic              read_n;
  logic              write_n;
  logic [REG_W-1:0]  writedata;
  logic [REG_W-1:0]  readdata;
  logic              irq;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/nios_cpu_pio_edge_sync.sv
// Two-flop synchronizer, previous-value stage, post-reset arming and edge detection.
module nios_cpu_pio_edge_sync
  import nios_cpu_pio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned EDGE_TYPE  = EDGE_RISING
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] i_in_port,
  output logic [DATA_WIDTH-1:0] o_sync_data,
  output logic [DATA_WIDTH-1:0] o_edge_pulse_c
);

  logic [DATA_WIDTH-1:0] r_sync1;
  logic [DATA_WIDTH-1:0] r_sync2;
  logic [DATA_WIDTH-1:0] r_prev;
  logic [ARM_W-1:0]      r_arm_cnt;
  logic                  w_armed;
  logic [DATA_WIDTH-1:0] w_edge;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_prev    <= '0;
      r_arm_cnt <= '0;
    end else begin
      r_sync1 <= i_in_port;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_arm_cnt != ARM_DONE) r_arm_cnt <= r_arm_cnt + ARM_W'(1);
    end
  end

  // Held off until prev has seen real data, so levels present at reset release never capture.
  assign w_armed = (r_arm_cnt == ARM_DONE);

  always_comb begin
    w_edge = '0;
    case (EDGE_TYPE)
      EDGE_RISING:  w_edge = r_sync2 & ~r_prev;
      EDGE_FALLING: w_edge = ~r_sync2 & r_prev;
      EDGE_ANY:     w_edge = r_sync2 ^ r_prev;
      default:      w_edge = '0;
    endcase
  end

  assign o_sync_data    = r_sync2;
  assign o_edge_pulse_c = w_armed ? w_edge : '0;

endmodule

// File: rtl/nios_cpu_pio_in.sv
// Avalon-MM input PIO: data/mask/edgecapture registers, 1-cycle read path and maskable irq.
module nios_cpu_pio_in
  import nios_cpu_pio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned EDGE_TYPE  = EDGE_RISING,
  parameter int unsigned IRQ_TYPE   = IRQ_EDGE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_port,
  nios_cpu_pio_in_if.slave      avs
);

  logic [DATA_WIDTH-1:0] w_sync_data;
  logic [DATA_WIDTH-1:0] w_edge_pulse;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_w1c;
  logic [REG_W-1:0]      w_rd_mux;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_irq;

  logic [DATA_WIDTH-1:0] r_mask;
  logic [DATA_WIDTH-1:0] r_edgecap;
  logic [REG_W-1:0]      r_readdata;

  nios_cpu_pio_edge_sync #(
    .DATA_WIDTH (DATA_WIDTH),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_edge_sync (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_in_port      (in_port),
    .o_sync_data    (w_sync_data),
    .o_edge_pulse_c (w_edge_pulse)
  );

  assign w_wr    = avs.chipselect & ~avs.write_n;
  assign w_rd    = avs.chipselect & ~avs.read_n;
  assign w_wdata = avs.writedata[DATA_WIDTH-1:0];
  assign w_w1c   = (w_wr && (avs.address == ADDR_EDGE)) ? w_wdata : '0;

  always_comb begin
    w_rd_mux = '0;
    case (avs.address)
      ADDR_DATA: w_rd_mux = REG_W'(w_sync_data);
      ADDR_DIR:  w_rd_mux = '0;
      ADDR_MASK: w_rd_mux = REG_W'(r_mask);
      ADDR_EDGE: w_rd_mux = REG_W'(r_edgecap);
      default:   w_rd_mux = '0;
    endcase
  end

  // A new edge is OR-ed in after the clear, so it survives a simultaneous W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask     <= '0;
      r_edgecap  <= '0;
      r_readdata <= '0;
    end else begin
      if (w_wr && (avs.address == ADDR_MASK)) r_mask <= w_wdata;
      r_edgecap <= (r_edgecap & ~w_w1c) | w_edge_pulse;
      if (w_rd) r_readdata <= w_rd_mux;
    end
  end

  always_comb begin
    w_irq = 1'b0;
    case (IRQ_TYPE)
      IRQ_EDGE:  w_irq = |(r_edgecap & r_mask);
      IRQ_LEVEL: w_irq = |(w_sync_data & r_mask);
      default:   w_irq = 1'b0;
    endcase
  end

  assign avs.readdata = r_readdata;
  assign avs.irq      = w_irq;

endmodule

// File: tb/tb_nios_cpu_pio_in.sv
// Three PIO builds share one bus and input; each is checked every cycle against a history model.
module tb_nios_cpu_pio_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  addr;
  logic        cs, rn, wn;
  logic [31:0] wd;
  logic [31:0] in_port;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] rdv [3];
  logic        irqv[3];

  // Model state: in_port sample taken at each clock edge since reset release.
  logic [31:0] hist[$];
  int          ncyc;
  logic [31:0] m_rd  [3];
  logic [31:0] m_mask[3];
  logic [31:0] m_cap [3];

  always #5 clk = ~clk;

  nios_cpu_pio_in_if bus0 ();
  nios_cpu_pio_in_if bus1 ();
  nios_cpu_pio_in_if bus2 ();

  assign bus0.address = addr; assign bus0.chipselect = cs; assign bus0.read_n = rn;
  assign bus0.write_n = wn;   assign bus0.writedata  = wd;
  assign bus1.address = addr; assign bus1.chipselect = cs; assign bus1.read_n = rn;
  assign bus1.write_n = wn;   assign bus1.writedata  = wd;
  assign bus2.address = addr; assign bus2.chipselect = cs; assign bus2.read_n = rn;
  assign bus2.write_n = wn;   assign bus2.writedata  = wd;

  assign rdv[0] = bus0.readdata; assign irqv[0] = bus0.irq;
  assign rdv[1] = bus1.readdata; assign irqv[1] = bus1.irq;
  assign rdv[2] = bus2.readdata; assign irqv[2] = bus2.irq;

  // Build 0: 32-bit rising, edge irq.  Build 1: 16-bit any-edge, edge irq.  Build 2: 8-bit falling, level irq.
  nios_cpu_pio_in #(.DATA_WIDTH(32), .EDGE_TYPE(0), .IRQ_TYPE(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_port(in_port), .avs(bus0));
  nios_cpu_pio_in #(.DATA_WIDTH(16), .EDGE_TYPE(2), .IRQ_TYPE(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_port(in_port[15:0]), .avs(bus1));
  nios_cpu_pio_in #(.DATA_WIDTH(8), .EDGE_TYPE(1), .IRQ_TYPE(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_port(in_port[7:0]), .avs(bus2));

  function automatic logic [31:0] wmask(int d);
    case (d)
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0000_FFFF;
      default: return 32'h0000_00FF;
    endcase
  endfunction

  function automatic logic [31:0] edgef(int d, logic [31:0] cur, logic [31:0] old);
    case (d)
      0:       return (cur & ~old) & wmask(d);
      1:       return (cur ^ old) & wmask(d);
      default: return (~cur & old) & wmask(d);
    endcase
  endfunction

  // Input sampled at edge j (j >= 1); nothing sampled before the first edge after reset.
  function automatic logic [31:0] h(int j);
    if (j >= 1 && j <= hist.size()) return hist[j-1];
    return 32'h0;
  endfunction

  function automatic logic exp_irq(int d);
    if (d == 2) return |(h(ncyc - 1) & wmask(d) & m_mask[d]);
    return |(m_cap[d] & m_mask[d]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s readdata%0d", tag, d), rdv[d], m_rd[d]);
      check($sformatf("%s irq%0d", tag, d), 32'(irqv[d]), 32'(exp_irq(d)));
    end
  endtask

  task automatic model_reset();
    hist.delete();
    ncyc = 0;
    for (int d = 0; d < 3; d++) begin
      m_rd[d] = '0; m_mask[d] = '0; m_cap[d] = '0;
    end
  endtask

  // One clock: model sees the bus/input held across the edge, then every output is compared.
  task automatic tick(input string tag = "cyc");
    int          k;
    logic [31:0] s2, pv, e, w1c;
    bit          rd, wr;
    @(posedge clk);
    k  = ncyc + 1;
    s2 = h(k - 2);
    pv = h(k - 3);
    rd = cs && !rn;
    wr = cs && !wn;
    for (int d = 0; d < 3; d++) begin
      e = (k >= 4) ? edgef(d, s2, pv) : 32'h0;
      if (rd) begin
        case (addr)
          3'd0:    m_rd[d] = s2 & wmask(d);
          3'd2:    m_rd[d] = m_mask[d];
          3'd3:    m_rd[d] = m_cap[d];
          default: m_rd[d] = 32'h0;
        endcase
      end
      w1c = (wr && addr == 3'd3) ? (wd & wmask(d)) : 32'h0;
      m_cap[d] = (m_cap[d] & ~w1c) | e;
      if (wr && addr == 3'd2) m_mask[d] = wd & wmask(d);
    end
    hist.push_back(in_port);
    ncyc = k;
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n);
    cs = 1'b0; rn = 1'b1; wn = 1'b1;
    repeat (n) tick("idle");
  endtask

  task automatic bus_read(input logic [2:0] a);
    addr = a; cs = 1'b1; rn = 1'b0; wn = 1'b1;
    tick("read");
    cs = 1'b0; rn = 1'b1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] data);
    addr = a; wd = data; cs = 1'b1; wn = 1'b0; rn = 1'b1;
    tick("write");
    cs = 1'b0; wn = 1'b1;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before the next edge.
  task automatic mid_reset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s readdata%0d", tag, d), rdv[d], 32'h0);
      check($sformatf("%s irq%0d", tag, d), 32'(irqv[d]), 32'h0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    addr = '0; cs = 1'b0; rn = 1'b1; wn = 1'b1; wd = '0;
    in_port = 32'hFFFF_FFFF;
    model_reset();
    #1 reset_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset readdata%0d", d), rdv[d], 32'h0);
      check($sformatf("reset irq%0d", d), 32'(irqv[d]), 32'h0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Inputs high at reset release produce no capture.
    idle(10);
    bus_read(3'd3);
    check("armed cap0", rdv[0], 32'h0);
    check("armed cap1", rdv[1], 32'h0);
    check("armed cap2", rdv[2], 32'h0);
    check("armed irq0", 32'(irqv[0]), 32'h0);
    bus_read(3'd0);
    check("data0", rdv[0], 32'hFFFF_FFFF);
    check("data1", rdv[1], 32'h0000_FFFF);
    check("data2", rdv[2], 32'h0000_00FF);

    // Rising capture, read collision, irq and W1C.
    in_port = 32'h0;
    idle(4);
    bus_write(3'd2, 32'h1);
    in_port = 32'h5;
    tick(); tick();
    bus_read(3'd3);
    check("collide pre-edge cap0", rdv[0], 32'h0);
    bus_read(3'd3);
    check("rise cap0", rdv[0], 32'h5);
    check("rise irq0", 32'(irqv[0]), 32'h1);
    bus_write(3'd3, 32'h1);
    bus_read(3'd3);
    check("w1c cap0", rdv[0], 32'h4);
    check("w1c irq0", 32'(irqv[0]), 32'h0);

    // W1C on bit 3 in the same cycle as a new rising edge on bit 3.
    bus_write(3'd2, 32'h9);
    in_port = 32'hD;
    idle(3);
    bus_read(3'd3);
    check("bit3 set cap0", rdv[0], 32'hC);
    in_port = 32'h5;
    idle(3);
    in_port = 32'hD;
    tick(); tick();
    bus_write(3'd3, 32'h8);
    bus_read(3'd3);
    check("edge beats w1c cap0", rdv[0], 32'hC);
    check("edge beats w1c irq0", 32'(irqv[0]), 32'h1);
    bus_write(3'd3, 32'h8);
    bus_read(3'd3);
    check("bit3 cleared cap0", rdv[0], 32'h4);

    // Bit 7 high then low: any-edge build captures both, falling build only the fall.
    bus_write(3'd3, 32'hFFFF_FFFF);
    in_port = 32'h8D;
    idle(3);
    bus_read(3'd3);
    check("any rise cap1", rdv[1], 32'h80);
    check("fall ignores rise cap2", rdv[2], 32'h0);
    bus_write(3'd3, 32'hFFFF_FFFF);
    in_port = 32'hD;
    idle(3);
    bus_read(3'd3);
    check("any fall cap1", rdv[1], 32'h80);
    check("fall cap2", rdv[2], 32'h80);

    // Width truncation, reserved address, read hold.
    bus_write(3'd2, 32'hDEAD_BEEF);
    bus_read(3'd2);
    check("mask0", rdv[0], 32'hDEAD_BEEF);
    check("mask1", rdv[1], 32'h0000_BEEF);
    check("mask2", rdv[2], 32'h0000_00EF);
    idle(1);
    check("hold1", rdv[1], 32'h0000_BEEF);
    bus_read(3'd5);
    check("reserved0", rdv[0], 32'h0);
    check("reserved1", rdv[1], 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    in_port = in_port ^ (32'h1 << $urandom_range(0, 31));
        2:       in_port = $urandom;
        default: ;
      endcase
      cs   = ($urandom_range(0, 3) != 0);
      rn   = 1'($urandom_range(0, 1));
      wn   = 1'($urandom_range(0, 1));
      addr = 3'($urandom_range(0, 7));
      wd   = $urandom;
      tick("rand");
    end
    cs = 1'b0; rn = 1'b1; wn = 1'b1;

    // Pending captures with irq asserted are wiped by reset.
    in_port = 32'h0;
    idle(4);
    bus_write(3'd3, 32'hFFFF_FFFF);
    in_port = 32'hFF;
    idle(3);
    bus_write(3'd2, 32'hFF);
    bus_read(3'd3);
    check("pre-reset cap0", rdv[0], 32'hFF);
    check("pre-reset irq0", 32'(irqv[0]), 32'h1);
    mid_reset("mid-reset");
    idle(10);
    bus_read(3'd3);
    check("post-reset cap0", rdv[0], 32'h0);
    check("post-reset cap1", rdv[1], 32'h0);
    check("post-reset cap2", rdv[2], 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
